// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES pad reader and the bridge downstream of it:
// button bit positions, FSM state encodings and a small sizing helper.
package nes_pad_reader_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value selectable so an
// idle line does not look like activity while reset is asserted.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES controller over latch/clock/data and reports the 8 buttons as a
// registered active-high byte with valid/changed strobes.
//
// state | meaning
// IDLE  | counting POLL_CYCLES between frames; waits for enable once elapsed
// LATCH | nes_latch high for LATCH_CYCLES
// LOW   | nes_clk low for HALF_CYCLES; samples data on its last cycle
// HIGH  | nes_clk high for HALF_CYCLES; controller shifts next bit
// DONE  | one cycle; publish shift register to buttons
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int LATCH_CYCLES = 1200,
    parameter int HALF_CYCLES  = 600,
    parameter int POLL_CYCLES  = 1_666_667
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       changed,
    output logic       busy
);

    localparam int CNT_MAX = max3(LATCH_CYCLES, HALF_CYCLES, POLL_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             data_sync;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_data_sync (
        .clk (clk),
        .rst (rst),
        .d   (nes_data),
        .q   (data_sync)
    );

    // IDLE counts up toward POLL_LAST and parks there while enable is low;
    // the timed phases count down from their load value to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (cnt_q == POLL_LAST) begin
                    if (enable) begin
                        state_d = ST_LATCH;
                        cnt_d   = LATCH_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_LATCH: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_LOW;
                    cnt_d   = HALF_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_LOW: begin
                if (cnt_q == CNT_ZERO) begin
                    shift_d[bit_q] = ~data_sync;
                    if (bit_q == 3'd7) begin
                        state_d = ST_DONE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = HALF_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HIGH: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_LOW;
                    cnt_d   = HALF_LOAD;
                    bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they are flop outputs
    // aligned exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
            buttons   <= 8'h00;
            valid     <= 1'b0;
            changed   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            nes_latch <= (state_d == ST_LATCH);
            nes_clk   <= (state_d == ST_HIGH);
            busy      <= (state_d != ST_IDLE);
            valid     <= (state_q == ST_DONE);
            changed   <= (state_q == ST_DONE) && (shift_q != buttons);
            if (state_q == ST_DONE) begin
                buttons <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural NES controller model
// (loads on latch, shifts on nes_clk rising, active-low data).
module tb_nes_pad_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic       valid;
    logic       changed;
    logic       busy;

    int passed = 0;
    int total  = 0;

    nes_pad_reader #(
        .LATCH_CYCLES (4),
        .HALF_CYCLES  (2),
        .POLL_CYCLES  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .buttons   (buttons),
        .valid     (valid),
        .changed   (changed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Controller model
    logic [7:0] pattern = 8'h00;
    logic [7:0] pad_sh  = 8'h00;
    always @(posedge nes_latch) pad_sh <= pattern;
    always @(posedge nes_clk)   pad_sh <= {1'b0, pad_sh[7:1]};
    assign nes_data = ~pad_sh[0];

    // Activity monitor, sampled just after each rising edge
    logic mon_clr = 1'b0;
    int   latch_hi, clk_hi, clk_rise, overlap, busy_hi, valid_cnt;
    logic prev_nclk;
    always @(posedge clk) begin
        #1;
        if (mon_clr) begin
            latch_hi = 0; clk_hi = 0; clk_rise = 0; overlap = 0;
            busy_hi = 0; valid_cnt = 0; prev_nclk = nes_clk;
        end else begin
            if (nes_latch) latch_hi++;
            if (nes_clk) clk_hi++;
            if (nes_clk && !prev_nclk) clk_rise++;
            if (nes_clk && nes_latch) overlap++;
            if (busy) busy_hi++;
            if (valid) valid_cnt++;
            prev_nclk = nes_clk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic wait_latch(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (nes_latch) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok, output logic [7:0] b, output logic c);
        ok = 1'b0;
        b  = 8'hxx;
        c  = 1'bx;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                b  = buttons;
                c  = changed;
                break;
            end
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] pat,
                            input logic [7:0] exp_b, input logic exp_c);
        bit         ok;
        logic [7:0] b;
        logic       c;
        pattern = pat;
        wait_valid(ok, b, c);
        check({tag, "_valid_seen"}, 32'(ok), 32'd1);
        check({tag, "_buttons"}, 32'(b), 32'(exp_b));
        check({tag, "_changed"}, 32'(c), 32'(exp_c));
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
        check({tag, "_buttons_hold"}, 32'(buttons), 32'(exp_b));
    endtask

    initial begin
        int         n;
        int         rises;
        bit         ok;
        logic [7:0] b;
        logic       c;
        logic       pclk;

        // 1: reset state and frame timing
        rst    = 1'b1;
        enable = 1'b1;
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_latch",   32'(nes_latch), 32'd0);
        check("rst_nclk",    32'(nes_clk),   32'd0);
        check("rst_buttons", 32'(buttons),   32'd0);
        check("rst_valid",   32'(valid),     32'd0);
        check("rst_changed", 32'(changed),   32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        mon_clr = 1'b0;
        rst     = 1'b0;
        wait_latch(n, ok);
        check("t1_latch_seen", 32'(ok), 32'd1);
        check("t1_idle_cycles", 32'(n), 32'd64);
        wait_valid(ok, b, c);
        check("t1_valid_seen", 32'(ok), 32'd1);
        check("t1_buttons", 32'(b), 32'h00);
        check("t1_changed", 32'(c), 32'd0);
        check("t1_latch_width", 32'(latch_hi), 32'd4);
        check("t1_nclk_rises", 32'(clk_rise), 32'd7);
        check("t1_nclk_high_total", 32'(clk_hi), 32'd14);
        check("t1_overlap", 32'(overlap), 32'd0);
        check("t1_busy_cycles", 32'(busy_hi), 32'd35);
        check("t1_valid_count", 32'(valid_cnt), 32'd1);
        check("t1_busy_at_valid", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(valid), 32'd0);

        // 2, 3: patterns
        do_frame("t2_a5",      8'hA5, 8'hA5, 1'b1);
        do_frame("t2_a5_rep",  8'hA5, 8'hA5, 1'b0);
        do_frame("t3_a_only",  8'h01, 8'h01, 1'b1);
        do_frame("t3_none",    8'h00, 8'h00, 1'b1);

        // 4: enable low holds off frames, start is immediate on return
        enable = 1'b0;
        clear_mon();
        repeat (500) @(negedge clk);
        check("t4_no_latch", 32'(latch_hi), 32'd0);
        check("t4_no_busy", 32'(busy_hi), 32'd0);
        check("t4_busy_now", 32'(busy), 32'd0);
        pattern = 8'h3C;
        enable  = 1'b1;
        @(negedge clk);
        check("t4_latch_next_cycle", 32'(nes_latch), 32'd1);
        wait_valid(ok, b, c);
        check("t4_valid_seen", 32'(ok), 32'd1);
        check("t4_buttons", 32'(b), 32'h3C);
        check("t4_changed", 32'(c), 32'd1);

        // 5: reset during HIGH of bit 3
        pattern = 8'hFF;
        wait_latch(n, ok);
        check("t5_latch_seen", 32'(ok), 32'd1);
        clear_mon();
        rises = 0;
        pclk  = nes_clk;
        for (int i = 0; i < 200; i++) begin
            if (nes_clk && !pclk) rises++;
            pclk = nes_clk;
            if (rises == 4) break;
            @(negedge clk);
        end
        check("t5_reached_bit3_high", 32'(rises), 32'd4);
        check("t5_nclk_high_before_rst", 32'(nes_clk), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_nclk", 32'(nes_clk), 32'd0);
        check("t5_rst_latch", 32'(nes_latch), 32'd0);
        check("t5_rst_buttons", 32'(buttons), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_latch(n, ok);
        check("t5_relatch_seen", 32'(ok), 32'd1);
        check("t5_idle_cycles", 32'(n), 32'd64);
        check("t5_no_partial_valid", 32'(valid_cnt), 32'd0);
        wait_valid(ok, b, c);
        check("t5_valid_seen", 32'(ok), 32'd1);
        check("t5_buttons", 32'(b), 32'hFF);
        check("t5_changed", 32'(c), 32'd1);

        // 6: enable dropped during LATCH still completes that frame only
        pattern = 8'h81;
        wait_latch(n, ok);
        check("t6_latch_seen", 32'(ok), 32'd1);
        enable = 1'b0;
        wait_valid(ok, b, c);
        check("t6_valid_seen", 32'(ok), 32'd1);
        check("t6_buttons", 32'(b), 32'h81);
        check("t6_changed", 32'(c), 32'd1);
        clear_mon();
        repeat (300) @(negedge clk);
        check("t6_no_more_latch", 32'(latch_hi), 32'd0);
        check("t6_no_more_valid", 32'(valid_cnt), 32'd0);
        check("t6_buttons_hold", 32'(buttons), 32'h81);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
